// File: rtl/elevator_call_scheduler.sv
// Per-car call scheduler: latches in-car and hall buttons, clears served calls, and runs a SCAN policy.
// Optional macro ELEV_SCHED_CANCEL_EN: edge-detected in-car buttons where a second press cancels the call.
module elevator_call_scheduler #(
  parameter int BUTTONS_WIDTH = 8,
  parameter int FLOOR_WIDTH   = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [BUTTONS_WIDTH-1:0] btn_num_in,
  input  logic [BUTTONS_WIDTH-1:0] btn_up_out,
  input  logic [BUTTONS_WIDTH-1:0] btn_down_out,
  input  logic [FLOOR_WIDTH-1:0]   current_floor,
  input  logic                     serve,
  output logic [FLOOR_WIDTH-1:0]   next_floor,
  output logic                     request_valid,
  output logic [1:0]               dir,
  output logic [BUTTONS_WIDTH-1:0] active_in_levels,
  output logic [BUTTONS_WIDTH-1:0] active_out_levels
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DOWN = 2'd1, ST_UP = 2'd2} state_t;

  // No hall-up call exists on the top floor, and no hall-down call on floor 0.
  localparam logic [BUTTONS_WIDTH-1:0] UP_MASK   = {1'b0, {(BUTTONS_WIDTH-1){1'b1}}};
  localparam logic [BUTTONS_WIDTH-1:0] DOWN_MASK = {{(BUTTONS_WIDTH-1){1'b1}}, 1'b0};

  state_t                   state_q, state_nxt;
  logic [BUTTONS_WIDTH-1:0] pend_in, pend_up, pend_down;
  logic [BUTTONS_WIDTH-1:0] pend_in_nxt;
  logic [BUTTONS_WIDTH-1:0] all, here, above, below;
  logic [BUTTONS_WIDTH-1:0] clr_in, clr_up, clr_down;
  logic [FLOOR_WIDTH-1:0]   lo_above, hi_below, tgt_nxt;
  int                       cur_i;

  assign cur_i = int'(current_floor);
  assign all   = pend_in | pend_up | pend_down;

  // An out-of-range floor leaves 'here' empty, so it never matches a call.
  always_comb begin
    here  = '0;
    above = '0;
    below = '0;
    for (int i = 0; i < BUTTONS_WIDTH; i++) begin
      here[i]  = (i == cur_i);
      above[i] = all[i] && (i > cur_i);
      below[i] = all[i] && (i < cur_i);
    end
  end

  always_comb begin
    lo_above = '0;
    hi_below = '0;
    for (int i = BUTTONS_WIDTH - 1; i >= 0; i--)
      if (above[i]) lo_above = FLOOR_WIDTH'(i);
    for (int i = 0; i < BUTTONS_WIDTH; i++)
      if (below[i]) hi_below = FLOOR_WIDTH'(i);
  end

  // A hall call is kept for the return trip unless the car is about to reverse here.
  assign clr_in   = serve ? here : '0;
  assign clr_up   = (serve && (state_q != ST_DOWN || below == '0)) ? here : '0;
  assign clr_down = (serve && (state_q != ST_UP   || above == '0)) ? here : '0;

`ifdef ELEV_SCHED_CANCEL_EN
  logic [BUTTONS_WIDTH-1:0] btn_num_q;
  logic [BUTTONS_WIDTH-1:0] num_rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) btn_num_q <= '0;
    else        btn_num_q <= btn_num_in;
  end

  assign num_rise    = btn_num_in & ~btn_num_q;
  assign pend_in_nxt = (num_rise & ~pend_in) | (~num_rise & pend_in & ~clr_in);
`else
  assign pend_in_nxt = (pend_in & ~clr_in) | btn_num_in;
`endif

  always_comb begin
    state_nxt = state_q;
    tgt_nxt   = next_floor;
    case (state_q)
      ST_IDLE: begin
        if ((all & here) != '0)   tgt_nxt = current_floor;
        else if (above != '0) begin state_nxt = ST_UP;   tgt_nxt = lo_above; end
        else if (below != '0) begin state_nxt = ST_DOWN; tgt_nxt = hi_below; end
      end
      ST_UP: begin
        if (((pend_in | pend_up) & here) != '0) tgt_nxt = current_floor;
        else if (above != '0)                   tgt_nxt = lo_above;
        else if ((pend_down & here) != '0)      tgt_nxt = current_floor;
        else if (below != '0) begin state_nxt = ST_DOWN; tgt_nxt = hi_below; end
        else                                    state_nxt = ST_IDLE;
      end
      ST_DOWN: begin
        if (((pend_in | pend_down) & here) != '0) tgt_nxt = current_floor;
        else if (below != '0)                     tgt_nxt = hi_below;
        else if ((pend_up & here) != '0)          tgt_nxt = current_floor;
        else if (above != '0) begin state_nxt = ST_UP; tgt_nxt = lo_above; end
        else                                      state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A press in the same cycle as a serve wins because it is OR-ed in after the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_in       <= '0;
      pend_up       <= '0;
      pend_down     <= '0;
      state_q       <= ST_IDLE;
      next_floor    <= '0;
      request_valid <= 1'b0;
    end else begin
      pend_in       <= pend_in_nxt;
      pend_up       <= (pend_up & ~clr_up) | (btn_up_out & UP_MASK);
      pend_down     <= (pend_down & ~clr_down) | (btn_down_out & DOWN_MASK);
      state_q       <= state_nxt;
      next_floor    <= tgt_nxt;
      request_valid <= (all != '0);
    end
  end

  assign dir               = state_q;
  assign active_in_levels  = pend_in;
  assign active_out_levels = pend_up | pend_down;

endmodule

// File: doc/elevator_call_scheduler.md
# elevator_call_scheduler

Request-side companion of the elevator car controller.
- Latches in-car and hall buttons.
- Clears calls as they are served at a floor.
- Runs a directional (SCAN) policy and presents a registered `next_floor` target plus travel direction, which the car FSM compares against its own floor to choose UP/DOWN/OPEN.
- Sits between the button inputs and the car controller; one instance per car.

## Interface
Parameters:
- `BUTTONS_WIDTH`, 8 — number of floors; one button bit per floor; must be ≤ 2^`FLOOR_WIDTH`.
- `FLOOR_WIDTH`, 3 — width of floor indices.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1 — system clock, rising edge.
- `reset` input 1 — asynchronous, active-low.
- `btn_num_in` input `BUTTONS_WIDTH` — in-car floor buttons, level, bit i = floor i.
- `btn_up_out` input `BUTTONS_WIDTH` — hall up calls; top-floor bit ignored.
- `btn_down_out` input `BUTTONS_WIDTH` — hall down calls; bit 0 ignored.
- `current_floor` input `FLOOR_WIDTH` — car position from the car controller.
- `serve` input 1 — one-cycle pulse when doors open at `current_floor`.
- `next_floor` output reg `FLOOR_WIDTH` — target floor.
- `request_valid` output reg 1 — 1 when any call is pending.
- `dir` output reg 2 — 0 idle, 1 down, 2 up (same encoding as `engine`).
- `active_in_levels` output reg `BUTTONS_WIDTH` — latched in-car calls.
- `active_out_levels` output reg `BUTTONS_WIDTH` — latched hall calls (up | down), for lamps.

## Operation
- **Internal registers:** `pend_in`, `pend_up`, `pend_down` (`BUTTONS_WIDTH` each), plus the direction state.
- **Call latching:** each cycle, `pend_x |= btn_x` (masked as above).
- **Derived sets:** `all = pend_in | pend_up | pend_down`. `above` = bits of `all` with index > `current_floor`; `below` = bits of `all` with index < `current_floor`.
- **State IDLE:**
  - If `all[cur]`, target = cur, stay IDLE.
  - Else if `above` ≠ 0, go to UP.
  - Else if `below` ≠ 0, go to DOWN.
  - Else stay IDLE; target holds its last value.
- **State UP:**
  - If `(pend_in | pend_up)[cur]`, target = cur.
  - Else if `above` ≠ 0, target = lowest set index in `above`.
  - Else if `pend_down[cur]`, target = cur.
  - Else if `below` ≠ 0, go to DOWN.
  - Else go to IDLE.
- **State DOWN:** mirror of UP — uses `pend_down`, highest set index in `below`, falls back to `pend_up[cur]`, reverses to UP, else IDLE.
- **`dir` output:** IDLE→0, UP→2, DOWN→1.
- **Serve clearing:** on `serve`:
  - Clear `pend_in[cur]`.
  - Clear `pend_up[cur]` if state is UP or IDLE, or if state is DOWN with `below` = 0.
  - Clear `pend_down[cur]` if state is DOWN or IDLE, or if state is UP with `above` = 0.
- **Press and serve on the same bit, same cycle:** the press wins and the bit stays set.
- **`current_floor` ≥ `BUTTONS_WIDTH`:** treated as no-call-here; `above`/`below` are computed normally.
- **Other outputs:** `request_valid = (all != 0)` after update. `active_in_levels = pend_in`; `active_out_levels = pend_up | pend_down`.

## Timing
- **Reset (async, `reset` = 0):** all pending registers = 0, state = IDLE, `next_floor` = 0, `request_valid` = 0, `dir` = 0, both `active_*` = 0.
- **Reset mid-operation:** drops every pending call immediately.
- **Latency:** a button sampled at edge N sets pending (and `active_*`) at edge N. `next_floor`, `dir` and `request_valid` reflect it at edge N+1.
- **`serve` clearing:** takes effect at the sampling edge; targets update one edge later.
- **Direction changes:** one state transition per clock; an UP→DOWN reversal takes effect on the edge after `above` becomes 0.
- **`serve` asserted more than one cycle:** each cycle is treated as a new serve (idempotent).

## Configuration
- **Macro:** `ELEV_SCHED_CANCEL_EN`.
- **Defined:** `btn_num_in` is edge-detected with one internal register per bit. A rising edge on a bit already set in `pend_in` clears it (second press cancels); a rising edge on a clear bit sets it. Holding a button has no further effect.
- **Undefined:** `btn_num_in` is level-latched as above and can never cancel; no edge registers are synthesized.

## Test plan
- Reset, then `current_floor`=0, pulse `btn_num_in`=0x20 → `active_in_levels`=0x20 at N, `next_floor`=5, `dir`=2, `request_valid`=1 at N+1.
- UP at floor 2 with calls in=0x40 and down=0x10 → `next_floor`=4 first.
  - `current_floor`=4, `serve` → down bit 4 stays set (UP with `above`≠0), `next_floor`=6.
- At floor 6, serve → `above`=0 → `dir`=1, `next_floor`=4.
  - Serve at 4 → all clear, `dir`=0, `request_valid`=0.
- Same cycle: `serve` at floor 3 and `btn_up_out`[3]=1 while IDLE → `pend_up`[3] remains 1, `next_floor`=3.
- Assert `reset`=0 asynchronously between edges while calls 0x0F are pending → all outputs 0 immediately, without waiting for a clock edge.
- With `ELEV_SCHED_CANCEL_EN`: press 7 twice (release between) → `active_in_levels` 0x80 then 0x00.
  - Held press → stays 0x80.
  - Without the macro, the second press leaves 0x80.
